// File: rtl/crypt_pkg.sv
// Shared constants, byte classes and helpers for the encrypt/decrypt pipes.
package crypt_pkg;

   localparam int unsigned ALPHA_N = 26;
   localparam int unsigned KEYS    = 3;
   localparam logic [7:0]  UPPER_A = 8'h41;
   localparam logic [7:0]  LOWER_A = 8'h61;

   typedef enum logic [1:0] {NON_ALPHA, UPPER, LOWER} alpha_cls_e;

   function automatic alpha_cls_e classify(input logic [7:0] b);
      if (b >= UPPER_A && b <= 8'h5A) return UPPER;
      if (b >= LOWER_A && b <= 8'h7A) return LOWER;
      return NON_ALPHA;
   endfunction

   function automatic logic is_alpha(input logic [7:0] b);
      return classify(b) != NON_ALPHA;
   endfunction

endpackage

// File: rtl/crypt_key_sched.sv
// Round-robin key index and rotating shift offset, shared by both pipe ends.
// kidx/off are the values the byte accepted on the coming edge must use.
module crypt_key_sched
   import crypt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
   input  logic       sync_clr,
   input  logic [2:0] rot_freq,
   output logic [1:0] kidx,
   output logic [4:0] off
);

   logic [1:0] kidx_q, kidx_d;
   logic [2:0] cnt_q, cnt_d, cnt_base;
   logic [4:0] off_q, off_d;

   // A clear on the same edge as an accepted byte is seen by that byte.
   assign kidx     = sync_clr ? 2'd0 : kidx_q;
   assign off      = sync_clr ? 5'd0 : off_q;
   assign cnt_base = sync_clr ? 3'd0 : cnt_q;

   always_comb begin
      kidx_d = kidx;
      cnt_d  = cnt_base;
      off_d  = off;
      if (adv) begin
         kidx_d = (kidx == 2'(KEYS - 1)) ? 2'd0 : kidx + 2'd1;
         if (rot_freq == 3'd0) begin
            cnt_d = 3'd0;
            off_d = 5'd0;
         end else if (cnt_base + 3'd1 == rot_freq) begin
            cnt_d = 3'd0;
            off_d = (off == 5'(ALPHA_N - 1)) ? 5'd0 : off + 5'd1;
         end else begin
            cnt_d = cnt_base + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kidx_q <= 2'd0;
         cnt_q  <= 3'd0;
         off_q  <= 5'd0;
      end else begin
         kidx_q <= kidx_d;
         cnt_q  <= cnt_d;
         off_q  <= off_d;
      end
   end

endmodule

// File: rtl/decrypt_pipe.sv
// Receive-side decryptor: key XOR removal, alpha classify, Caesar un-shift, output.
// Input capture plus four stages give dout four edges after the accepting edge.
module decrypt_pipe
   import crypt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] din,
   input  logic [7:0] k1,
   input  logic [7:0] k2,
   input  logic [7:0] k3,
   input  logic       mode,
   input  logic       shift_en,
   input  logic [3:0] shift_amt,
   input  logic [2:0] rot_freq,
   input  logic       sync_clr,
   output logic       v,
   output logic [7:0] dout
);

   logic [1:0] kidx;
   logic [4:0] off;
   logic [7:0] key_sel;

   crypt_key_sched u_sched (
      .clk      (clk),
      .rst      (rst),
      .adv      (en),
      .sync_clr (sync_clr),
      .rot_freq (rot_freq),
      .kidx     (kidx),
      .off      (off)
   );

   always_comb begin
      case (kidx)
         2'd1:    key_sel = k2;
         2'd2:    key_sel = k3;
         default: key_sel = k1;
      endcase
   end

   // Stage 0: sampled byte with its config, key and offset
   logic       s0_v, s0_mode, s0_shift_en;
   logic [7:0] s0_din, s0_key;
   logic [3:0] s0_amt;
   logic [4:0] s0_off;
   // Stage 1: key removed
   logic       s1_v, s1_shift_en;
   logic [7:0] s1_x;
   logic [3:0] s1_amt;
   logic [4:0] s1_off;
   // Stage 2: classified, index and effective shift
   logic       s2_v, s2_shift_en;
   logic [7:0] s2_x;
   alpha_cls_e s2_cls;
   logic [4:0] s2_idx, s2_s;
   // Stage 3: un-shifted byte
   logic       s3_v;
   logic [7:0] s3_y;

   logic [7:0] s1_x_d, s1_base, s3_base, s3_y_d;
   logic [5:0] s2_sum, s3_diff;
   logic [4:0] s2_s_d, s2_idx_d, s3_idx;
   alpha_cls_e s2_cls_d;

   always_comb begin
      s1_x_d   = s0_mode ? (s0_din ^ s0_key) : s0_din;

      s2_cls_d = classify(s1_x);
      s1_base  = (s2_cls_d == LOWER) ? LOWER_A : UPPER_A;
      s2_idx_d = 5'(s1_x - s1_base);
      s2_sum   = {2'b00, s1_amt} + {1'b0, s1_off};
      s2_s_d   = (s2_sum >= 6'(ALPHA_N)) ? 5'(s2_sum - 6'(ALPHA_N)) : s2_sum[4:0];

      s3_diff  = {1'b0, s2_idx} - {1'b0, s2_s};
      s3_idx   = s3_diff[5] ? 5'(s3_diff + 6'(ALPHA_N)) : s3_diff[4:0];
      s3_base  = (s2_cls == LOWER) ? LOWER_A : UPPER_A;
      s3_y_d   = (s2_shift_en && s2_cls != NON_ALPHA) ? s3_base + {3'b000, s3_idx} : s2_x;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_v        <= 1'b0;
         s0_mode     <= 1'b0;
         s0_shift_en <= 1'b0;
         s0_din      <= 8'h00;
         s0_key      <= 8'h00;
         s0_amt      <= 4'd0;
         s0_off      <= 5'd0;
         s1_v        <= 1'b0;
         s1_shift_en <= 1'b0;
         s1_x        <= 8'h00;
         s1_amt      <= 4'd0;
         s1_off      <= 5'd0;
         s2_v        <= 1'b0;
         s2_shift_en <= 1'b0;
         s2_x        <= 8'h00;
         s2_cls      <= NON_ALPHA;
         s2_idx      <= 5'd0;
         s2_s        <= 5'd0;
         s3_v        <= 1'b0;
         s3_y        <= 8'h00;
         v           <= 1'b0;
         dout        <= 8'h00;
      end else begin
         s0_v        <= en;
         s0_mode     <= mode;
         s0_shift_en <= shift_en;
         s0_din      <= din;
         s0_key      <= key_sel;
         s0_amt      <= shift_amt;
         s0_off      <= off;
         s1_v        <= s0_v;
         s1_shift_en <= s0_shift_en;
         s1_x        <= s1_x_d;
         s1_amt      <= s0_amt;
         s1_off      <= s0_off;
         s2_v        <= s1_v;
         s2_shift_en <= s1_shift_en;
         s2_x        <= s1_x;
         s2_cls      <= s2_cls_d;
         s2_idx      <= s2_idx_d;
         s2_s        <= s2_s_d;
         s3_v        <= s2_v;
         s3_y        <= s3_y_d;
         v           <= s3_v;
         if (s3_v) dout <= s3_y;
      end
   end

endmodule
